sample_sdiv_14_seq: RTL

Sequential signed 14-bit divider, the inverse companion of the pipelined 14-bit signed multiplier in the HLS datapath. Accepts one dividend/divisor pair on a start handshake, runs a radix-2 restoring division over WIDTH iterations, and returns a truncated-toward-zero quotient and remainder with a one-cycle done pulse. It sits beside the multiplier units and shares their clock/reset/clock-enable scheme.

---
 rtl/sample_sdiv_14_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/sample_sdiv_14_seq.sv
// Sequential signed divider: radix-2 restoring, WIDTH iterations, C truncating semantics.
// Optional div_by_zero output port enabled by defining SAMPLE_SDIV_DBZ_FLAG_EN.
module sample_sdiv_14_seq #(
   parameter int WIDTH = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
`ifdef SAMPLE_SDIV_DBZ_FLAG_EN
   ,
   output logic             div_by_zero
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic [WIDTH:0] pr;          // partial remainder, one guard bit
   logic [WIDTH-1:0] dq;        // dividend magnitude, quotient bits shift in at LSB
   logic [WIDTH-1:0] dvs;
   logic           qneg, rneg, dbz;
   logic [WIDTH:0] shifted, diff;
   logic [WIDTH-1:0] qfix, rfix;

   assign ready   = (state == IDLE);
   assign shifted = {pr[WIDTH-1:0], dq[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs};

   // A zero divisor forces quotient -1; the remainder magnitude already equals |dividend|.
   assign qfix = dbz ? '1 : (qneg ? -dq : dq);
   assign rfix = rneg ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = BUSY;
         BUSY:    if (cnt == CW'(WIDTH-1)) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         pr        <= '0;
         dq        <= '0;
         dvs       <= '0;
         qneg      <= 1'b0;
         rneg      <= 1'b0;
         dbz       <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (ce) begin
         state <= state_nx;
         done  <= (state == FIX);
         case (state)
            IDLE: if (start) begin
               dq   <= dividend[WIDTH-1] ? -dividend : dividend;
               dvs  <= divisor[WIDTH-1]  ? -divisor  : divisor;
               qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
               rneg <= dividend[WIDTH-1];
               dbz  <= (divisor == '0);
               pr   <= '0;
               cnt  <= '0;
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               dq  <= {dq[WIDTH-2:0], ~diff[WIDTH]};
               pr  <= diff[WIDTH] ? shifted : diff;
            end
            FIX: begin
               quotient  <= qfix;
               remainder <= rfix;
            end
            default: ;
         endcase
      end
   end

`ifdef SAMPLE_SDIV_DBZ_FLAG_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div_by_zero <= 1'b0;
      else if (ce && state == FIX)
         div_by_zero <= dbz;
   end
`endif

endmodule
